// File: rtl/mcycle_issue_scheduler_pkg.sv
// Shared core-level definitions for the issue scheduler: thread indexing,
// execute-pipe selection and the multi-cycle arithmetic stage count.
`default_nettype none

package mcycle_issue_scheduler_pkg;

    localparam int THREADS_PER_CORE = 4;
    localparam int MCYCLE_STAGES    = 5;

    typedef logic [$clog2(THREADS_PER_CORE)-1:0] thread_idx_t;

    typedef enum logic {
        PIPE_SINGLE_CYCLE = 1'b0,
        PIPE_MCYCLE_ARITH = 1'b1
    } pipeline_sel_t;

    function automatic pipeline_sel_t pipe_sel(input logic mcycle);
        return mcycle ? PIPE_MCYCLE_ARITH : PIPE_SINGLE_CYCLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mcycle_issue_scheduler_rr_arbiter.sv
// N-way round-robin arbiter: combinational grant, priority pointer advances
// past the winner when update_en_i is set.
`default_nettype none

module mcycle_issue_scheduler_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     request_i,
    input  logic             update_en_i,
    output logic [N-1:0]     grant_oh_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_oh_o    = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % N);
            if (!grant_valid_o && request_i[cand]) begin
                grant_valid_o    = 1'b1;
                grant_idx_o      = cand;
                grant_oh_o[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (update_en_i && grant_valid_o) begin
            ptr_q <= (grant_idx_o == IDX_W'(N - 1)) ? '0 : grant_idx_o + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mcycle_issue_scheduler.sv
// Per-core issue arbiter with a writeback-port reservation shift register that
// keeps single-cycle results from colliding with earlier multi-cycle results.
`default_nettype none

module mcycle_issue_scheduler
    import mcycle_issue_scheduler_pkg::*;
#(
    parameter int THREADS    = THREADS_PER_CORE,
    parameter int MC_LATENCY = MCYCLE_STAGES,
    parameter int SC_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [THREADS-1:0]         ts_request_i,
    input  logic [THREADS-1:0]         ts_pipe_mcycle_i,
    input  logic                       wb_rollback_en_i,
    input  logic [$clog2(THREADS)-1:0] wb_rollback_thread_idx_i,
    output logic                       is_issue_valid_o,
    output logic [$clog2(THREADS)-1:0] is_issue_thread_idx_o,
    output logic                       is_issue_mcycle_o,
    output logic [THREADS-1:0]         is_grant_oh_o,
    output logic                       is_wb_valid_o,
    output logic [$clog2(THREADS)-1:0] is_wb_thread_idx_o,
    output logic [THREADS-1:0]         is_mc_busy_o
);

    localparam int TIDX_W = $clog2(THREADS);
    localparam int CNT_W  = $clog2(MC_LATENCY + 2);

    logic [THREADS-1:0] eligible;
    logic [THREADS-1:0] grant_oh;
    logic [TIDX_W-1:0]  grant_idx;
    logic               grant_valid;
    pipeline_sel_t      grant_sel;

    // Slot k holds the writeback happening k cycles from now.
    logic [MC_LATENCY:0] res_valid_q, res_valid_d;
    logic [MC_LATENCY:0] res_mc_q, res_mc_d;
    logic [TIDX_W-1:0]   res_thread_q [MC_LATENCY+1];
    logic [TIDX_W-1:0]   res_thread_d [MC_LATENCY+1];

    logic [CNT_W-1:0]    mc_cnt_q [THREADS];
    logic [CNT_W-1:0]    mc_cnt_d [THREADS];
    logic [THREADS-1:0]  mc_inc;
    logic [THREADS-1:0]  mc_dec;

    logic                issue_valid_q;
    logic [TIDX_W-1:0]   issue_thread_q;
    logic                issue_mcycle_q;
    logic [THREADS-1:0]  grant_oh_q;

    // A single-cycle op lands in slot SC_LATENCY after the shift, so it must
    // see slot SC_LATENCY+1 free before the shift.
    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            eligible[t] = ts_request_i[t]
                && !(wb_rollback_en_i && (wb_rollback_thread_idx_i == TIDX_W'(t)))
                && (ts_pipe_mcycle_i[t] || !res_valid_q[SC_LATENCY + 1]);
        end
    end

    mcycle_issue_scheduler_rr_arbiter #(
        .N (THREADS)
    ) u_rr_arbiter (
        .clk           (clk),
        .reset         (reset),
        .request_i     (eligible),
        .update_en_i   (1'b1),
        .grant_oh_o    (grant_oh),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    assign grant_sel = pipe_sel(ts_pipe_mcycle_i[grant_idx]);

    always_comb begin
        for (int k = 0; k < MC_LATENCY; k++) begin
            res_valid_d[k]  = res_valid_q[k + 1];
            res_mc_d[k]     = res_mc_q[k + 1];
            res_thread_d[k] = res_thread_q[k + 1];
        end
        res_valid_d[MC_LATENCY]  = 1'b0;
        res_mc_d[MC_LATENCY]     = 1'b0;
        res_thread_d[MC_LATENCY] = '0;

        if (wb_rollback_en_i) begin
            for (int k = 0; k <= MC_LATENCY; k++) begin
                if (res_thread_d[k] == wb_rollback_thread_idx_i) begin
                    res_valid_d[k] = 1'b0;
                    res_mc_d[k]    = 1'b0;
                end
            end
        end

        if (grant_valid) begin
            if (grant_sel == PIPE_MCYCLE_ARITH) begin
                res_valid_d[MC_LATENCY]  = 1'b1;
                res_mc_d[MC_LATENCY]     = 1'b1;
                res_thread_d[MC_LATENCY] = grant_idx;
            end else begin
                res_valid_d[SC_LATENCY]  = 1'b1;
                res_mc_d[SC_LATENCY]     = 1'b0;
                res_thread_d[SC_LATENCY] = grant_idx;
            end
        end
    end

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            mc_inc[t] = grant_valid && (grant_sel == PIPE_MCYCLE_ARITH)
                        && (grant_idx == TIDX_W'(t));
            mc_dec[t] = res_valid_q[0] && res_mc_q[0]
                        && (res_thread_q[0] == TIDX_W'(t));
            mc_cnt_d[t] = mc_cnt_q[t];
            // Rollback wipes every entry of the thread, so its count drops to zero.
            if (wb_rollback_en_i && (wb_rollback_thread_idx_i == TIDX_W'(t))) begin
                mc_cnt_d[t] = '0;
            end else if (mc_inc[t] && !mc_dec[t]) begin
                mc_cnt_d[t] = mc_cnt_q[t] + CNT_W'(1);
            end else if (mc_dec[t] && !mc_inc[t]) begin
                mc_cnt_d[t] = mc_cnt_q[t] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid_q  <= 1'b0;
            issue_thread_q <= '0;
            issue_mcycle_q <= 1'b0;
            grant_oh_q     <= '0;
            res_valid_q    <= '0;
            res_mc_q       <= '0;
            for (int k = 0; k <= MC_LATENCY; k++) begin
                res_thread_q[k] <= '0;
            end
            for (int t = 0; t < THREADS; t++) begin
                mc_cnt_q[t] <= '0;
            end
        end else begin
            issue_valid_q  <= grant_valid;
            issue_thread_q <= grant_idx;
            issue_mcycle_q <= grant_valid && (grant_sel == PIPE_MCYCLE_ARITH);
            grant_oh_q     <= grant_oh;
            res_valid_q    <= res_valid_d;
            res_mc_q       <= res_mc_d;
            res_thread_q   <= res_thread_d;
            mc_cnt_q       <= mc_cnt_d;
        end
    end

    always_comb begin
        for (int t = 0; t < THREADS; t++) begin
            is_mc_busy_o[t] = (mc_cnt_q[t] != '0);
        end
    end

    assign is_issue_valid_o      = issue_valid_q;
    assign is_issue_thread_idx_o = issue_thread_q;
    assign is_issue_mcycle_o     = issue_mcycle_q;
    assign is_grant_oh_o         = grant_oh_q;
    assign is_wb_valid_o         = res_valid_q[0];
    assign is_wb_thread_idx_o    = res_thread_q[0];

endmodule

`default_nettype wire

// File: tb/tb_mcycle_issue_scheduler.sv
// Directed bench for mcycle_issue_scheduler (THREADS=4, MC_LATENCY=5, SC_LATENCY=1).
`default_nettype none

module tb_mcycle_issue_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] ts_request;
    logic [3:0] ts_pipe_mcycle;
    logic       rb_en;
    logic [1:0] rb_idx;
    logic       issue_valid;
    logic [1:0] issue_idx;
    logic       issue_mcycle;
    logic [3:0] grant_oh;
    logic       wb_valid;
    logic [1:0] wb_idx;
    logic [3:0] mc_busy;

    int compared   = 0;
    int mismatched = 0;

    mcycle_issue_scheduler dut (
        .clk                      (clk),
        .reset                    (reset),
        .ts_request_i             (ts_request),
        .ts_pipe_mcycle_i         (ts_pipe_mcycle),
        .wb_rollback_en_i         (rb_en),
        .wb_rollback_thread_idx_i (rb_idx),
        .is_issue_valid_o         (issue_valid),
        .is_issue_thread_idx_o    (issue_idx),
        .is_issue_mcycle_o        (issue_mcycle),
        .is_grant_oh_o            (grant_oh),
        .is_wb_valid_o            (wb_valid),
        .is_wb_thread_idx_o       (wb_idx),
        .is_mc_busy_o             (mc_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        ts_request     = '0;
        ts_pipe_mcycle = '0;
        rb_en          = 1'b0;
        rb_idx         = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [3:0] cur_req, cur_mc, exp_oh;
    logic       cur_rb_en;
    logic [1:0] cur_rb_idx;

    initial begin
        do_reset();
        check("rst_valid",  32'(issue_valid), 32'd0);
        check("rst_oh",     32'(grant_oh),    32'd0);
        check("rst_wb",     32'(wb_valid),    32'd0);
        check("rst_busy",   32'(mc_busy),     32'd0);

        // All threads multi-cycle: strict rotation, first writeback 5 cycles later.
        ts_request = 4'hF; ts_pipe_mcycle = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_valid",   32'(issue_valid),  32'd1);
            check("t1_idx",     32'(issue_idx),    32'(i % 4));
            check("t1_mcycle",  32'(issue_mcycle), 32'd1);
            check("t1_wb_idle", 32'(wb_valid),     32'd0);
        end
        check("t1_busy", 32'(mc_busy), 32'hF);
        ts_request = 4'h0;
        tick();
        check("t1_wb_valid", 32'(wb_valid),    32'd1);
        check("t1_wb_idx",   32'(wb_idx),      32'd0);
        check("t1_no_issue", 32'(issue_valid), 32'd0);
        tick();
        check("t1_wb_idx2",  32'(wb_idx), 32'd1);

        // Single-cycle thread stalls exactly once behind a multi-cycle op.
        do_reset();
        ts_request = 4'b0001; ts_pipe_mcycle = 4'b0001;
        tick();
        check("t2_mc_idx",    32'(issue_idx),    32'd0);
        check("t2_mc_flag",   32'(issue_mcycle), 32'd1);
        ts_request = 4'b0010; ts_pipe_mcycle = 4'b0000;
        tick();
        check("t2_sc_valid",  32'(issue_valid),  32'd1);
        check("t2_sc_idx",    32'(issue_idx),    32'd1);
        check("t2_sc_flag",   32'(issue_mcycle), 32'd0);
        tick();
        check("t2_c3_valid",  32'(issue_valid),  32'd1);
        check("t2_c3_wb",     32'(wb_valid),     32'd1);
        check("t2_c3_wbidx",  32'(wb_idx),       32'd1);
        tick();
        check("t2_c4_valid",  32'(issue_valid),  32'd1);
        tick();
        check("t2_blocked",   32'(issue_valid),  32'd0);
        check("t2_c5_wbidx",  32'(wb_idx),       32'd1);
        tick();
        check("t2_resume",    32'(issue_valid),  32'd1);
        check("t2_resume_idx",32'(issue_idx),    32'd1);
        check("t2_mc_wb",     32'(wb_valid),     32'd1);
        check("t2_mc_wbidx",  32'(wb_idx),       32'd0);
        ts_request = 4'b0000;
        tick();
        check("t2_c7_wb",     32'(wb_valid),     32'd1);
        check("t2_c7_wbidx",  32'(wb_idx),       32'd1);
        tick();
        check("t2_c8_wb",     32'(wb_valid),     32'd0);

        // Rollback of thread 2 clears its three ops but keeps thread 3's.
        do_reset();
        ts_request = 4'b0100; ts_pipe_mcycle = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_idx2", 32'(issue_idx), 32'd2);
        end
        ts_request = 4'b1000; ts_pipe_mcycle = 4'b1000;
        tick();
        check("t3_idx3",     32'(issue_idx), 32'd3);
        check("t3_busy_pre", 32'(mc_busy),   32'hC);
        ts_request = 4'b0000; rb_en = 1'b1; rb_idx = 2'd2;
        tick();
        rb_en = 1'b0;
        check("t3_busy_post", 32'(mc_busy),     32'h8);
        check("t3_no_issue",  32'(issue_valid), 32'd0);
        check("t3_wb_c5",     32'(wb_valid),    32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_wb_squashed", 32'(wb_valid), 32'd0);
        end
        tick();
        check("t3_wb_t3",     32'(wb_valid), 32'd1);
        check("t3_wb_t3_idx", 32'(wb_idx),   32'd3);
        tick();
        check("t3_busy_end",  32'(mc_busy),  32'h0);

        // Rollback masks the sole requester; pointer must stay at 2.
        do_reset();
        ts_request = 4'b0010; ts_pipe_mcycle = 4'b0000;
        tick();
        check("t4_first_idx", 32'(issue_idx), 32'd1);
        rb_en = 1'b1; rb_idx = 2'd1;
        tick();
        check("t4_masked",    32'(issue_valid), 32'd0);
        check("t4_masked_oh", 32'(grant_oh),    32'd0);
        check("t4_wb_clear",  32'(wb_valid),    32'd0);
        rb_en = 1'b0; ts_request = 4'hF;
        tick();
        check("t4_ptr_idx",   32'(issue_idx), 32'd2);
        check("t4_ptr_oh",    32'(grant_oh),  32'h4);
        tick();
        check("t4_next_idx",  32'(issue_idx), 32'd3);
        check("t4_wb_idx",    32'(wb_idx),    32'd2);
        ts_request = 4'h0;

        // Asynchronous reset with reservations in flight.
        do_reset();
        ts_request = 4'hF; ts_pipe_mcycle = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        ts_request = 4'h0;
        check("t5_busy_pre", 32'(mc_busy), 32'hF);
        #3 reset = 1'b1;
        #1;
        check("t5_async_valid", 32'(issue_valid), 32'd0);
        check("t5_async_oh",    32'(grant_oh),    32'd0);
        check("t5_async_busy",  32'(mc_busy),     32'd0);
        check("t5_async_wb",    32'(wb_valid),    32'd0);
        #1 reset = 1'b0;
        ts_request = 4'b0100; ts_pipe_mcycle = 4'b0100;
        tick();
        check("t5_new_idx", 32'(issue_idx), 32'd2);
        ts_request = 4'h0;
        check("t5_wb_quiet", 32'(wb_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_wb_quiet", 32'(wb_valid), 32'd0);
        end
        tick();
        check("t5_wb_new",     32'(wb_valid), 32'd1);
        check("t5_wb_new_idx", 32'(wb_idx),   32'd2);

        // Mixed random traffic: grant legality against what was driven.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cur_req    = 4'($urandom_range(0, 15));
            cur_mc     = 4'($urandom_range(0, 15));
            cur_rb_en  = ($urandom_range(0, 7) == 0);
            cur_rb_idx = 2'($urandom_range(0, 3));
            ts_request = cur_req; ts_pipe_mcycle = cur_mc;
            rb_en = cur_rb_en; rb_idx = cur_rb_idx;
            tick();
            check("rnd_onehot0", 32'($onehot0(grant_oh)), 32'd1);
            if (issue_valid) begin
                exp_oh = 4'b0001 << issue_idx;
                check("rnd_oh_idx",    32'(grant_oh),            32'(exp_oh));
                check("rnd_requested", 32'(cur_req[issue_idx]),  32'd1);
                check("rnd_not_rb",    32'(cur_rb_en && (cur_rb_idx == issue_idx)), 32'd0);
                check("rnd_mcycle",    32'(issue_mcycle),        32'(cur_mc[issue_idx]));
            end else begin
                check("rnd_idle_oh",   32'(grant_oh),            32'd0);
            end
        end
        rb_en = 1'b0; ts_request = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
